// File: rtl/dmx_axi_wr_arb.sv
// Round-robin write arbiter: shares one address + write-data master port
// between NUM_REQ demux write engines. A grant covers one whole burst
// (address phase then all data beats). Priority rotates after the burst,
// and beat count vs. alen mismatches raise a sticky err_len.
module dmx_axi_wr_arb #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64
) (
  input  logic                         gclk,
  input  logic                         greset,
  input  logic [NUM_REQ-1:0]           s_avalid,
  output logic [NUM_REQ-1:0]           s_aready,
  input  logic [NUM_REQ*6-1:0]         s_aid,
  input  logic [NUM_REQ*ADDR_W-1:0]    s_addr,
  input  logic [NUM_REQ-1:0]           s_awrite,
  input  logic [NUM_REQ*4-1:0]         s_alen,
  input  logic [NUM_REQ*2-1:0]         s_aburst,
  input  logic [NUM_REQ*2-1:0]         s_asize,
  input  logic [NUM_REQ-1:0]           s_wvalid,
  output logic [NUM_REQ-1:0]           s_wready,
  input  logic [NUM_REQ*6-1:0]         s_wid,
  input  logic [NUM_REQ*DATA_W-1:0]    s_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]  s_wstrb,
  input  logic [NUM_REQ-1:0]           s_wlast,
  output logic                         m_avalid,
  input  logic                         m_aready,
  output logic [5:0]                   m_aid,
  output logic [ADDR_W-1:0]            m_addr,
  output logic                         m_awrite,
  output logic [3:0]                   m_alen,
  output logic [1:0]                   m_aburst,
  output logic [1:0]                   m_asize,
  output logic                         m_wvalid,
  input  logic                         m_wready,
  output logic [5:0]                   m_wid,
  output logic [DATA_W-1:0]            m_wdata,
  output logic [DATA_W/8-1:0]          m_wstrb,
  output logic                         m_wlast,
  output logic [IDX_W-1:0]             grant_idx,
  output logic                         busy,
  output logic                         err_len,
  input  logic                         err_clr
);
  localparam int STRB_W = DATA_W/8;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_grant, r_rr_ptr;
  logic [3:0]       r_cnt;
  logic             r_busy, r_err;

  logic [IDX_W-1:0] w_sel, w_idx, w_next;
  logic             w_any, w_aph, w_dph;
  logic             w_cnt_zero, w_glast, w_ahs, w_whs, w_end, w_err;
  int               j;

  // First requesting index scanning upward from rr_ptr with wrap; the
  // reverse walk lets the smallest offset from rr_ptr win.
  always_comb begin
    w_sel = r_rr_ptr;
    w_any = 1'b0;
    w_idx = '0;
    j     = 0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      w_idx = IDX_W'(j);
      if (s_avalid[w_idx]) begin
        w_sel = w_idx;
        w_any = 1'b1;
      end
    end
  end

  assign w_aph      = (r_state == ADDR);
  assign w_dph      = (r_state == DATA);
  assign w_next     = (r_grant == IDX_W'(NUM_REQ-1)) ? '0 : r_grant + 1'b1;

  // Address channel is a straight mux of the owner, zeroed outside ADDR
  assign m_avalid = w_aph & s_avalid[r_grant];
  assign m_aid    = w_aph ? s_aid   [r_grant*6      +: 6]      : '0;
  assign m_addr   = w_aph ? s_addr  [r_grant*ADDR_W +: ADDR_W] : '0;
  assign m_awrite = w_aph & s_awrite[r_grant];
  assign m_alen   = w_aph ? s_alen  [r_grant*4      +: 4]      : '0;
  assign m_aburst = w_aph ? s_aburst[r_grant*2      +: 2]      : '0;
  assign m_asize  = w_aph ? s_asize [r_grant*2      +: 2]      : '0;

  // Data channel mux; wlast is forced when the counter runs out so the
  // interconnect always sees a terminated burst.
  assign w_cnt_zero = (r_cnt == 4'd0);
  assign w_glast    = s_wlast[r_grant];
  assign m_wvalid   = w_dph & s_wvalid[r_grant];
  assign m_wid      = w_dph ? s_wid  [r_grant*6      +: 6]      : '0;
  assign m_wdata    = w_dph ? s_wdata[r_grant*DATA_W +: DATA_W] : '0;
  assign m_wstrb    = w_dph ? s_wstrb[r_grant*STRB_W +: STRB_W] : '0;
  assign m_wlast    = w_dph & (w_glast | w_cnt_zero);

  assign w_ahs = m_avalid & m_aready;
  assign w_whs = m_wvalid & m_wready;
  assign w_end = w_whs & (w_glast | w_cnt_zero);
  assign w_err = w_whs & (w_glast ^ w_cnt_zero);

  // Only the owner sees ready, and only in its current phase
  always_comb begin
    s_aready = '0;
    s_wready = '0;
    if (w_aph) s_aready[r_grant] = m_aready;
    if (w_dph) s_wready[r_grant] = m_wready;
  end

  // Burst-ownership FSM with rotating priority and sticky length error
  always_ff @(posedge gclk) begin
    if (greset) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_err)        r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
      case (r_state)
        IDLE: if (w_any) begin
          r_grant <= w_sel;
          r_busy  <= 1'b1;
          r_state <= ADDR;
        end
        ADDR: if (w_ahs) begin
          r_cnt   <= m_alen;
          r_state <= DATA;
        end
        DATA: begin
          if (w_whs) r_cnt <= r_cnt - 4'd1;
          if (w_end) begin
            r_rr_ptr <= w_next;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant_idx = r_grant;
  assign busy      = r_busy;
  assign err_len   = r_err;

endmodule

// File: tb/tb_dmx_axi_wr_arb.sv
// Bench for dmx_axi_wr_arb: behavioural requester engines drive bursts,
// per-requester scoreboards hold the expected address and beats, and a
// negedge monitor pops and compares on every master handshake.
module tb_dmx_axi_wr_arb;
  localparam int NR = 2, IW = 1, AW = 32, DW = 64, SW = DW/8;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic              greset  = 1'b1;
  logic              err_clr = 1'b0;
  logic [NR-1:0]     s_avalid = '0, s_awrite = '0, s_wvalid = '0, s_wlast = '0;
  logic [NR-1:0]     s_aready, s_wready;
  logic [NR*6-1:0]   s_aid = '0, s_wid = '0;
  logic [NR*AW-1:0]  s_addr = '0;
  logic [NR*4-1:0]   s_alen = '0;
  logic [NR*2-1:0]   s_aburst = '0, s_asize = '0;
  logic [NR*DW-1:0]  s_wdata = '0;
  logic [NR*SW-1:0]  s_wstrb = '0;
  logic              m_aready = 1'b0, m_wready = 1'b0;
  logic              m_avalid, m_awrite, m_wvalid, m_wlast, busy, err_len;
  logic [5:0]        m_aid, m_wid;
  logic [AW-1:0]     m_addr;
  logic [3:0]        m_alen;
  logic [1:0]        m_aburst, m_asize;
  logic [DW-1:0]     m_wdata;
  logic [SW-1:0]     m_wstrb;
  logic [IW-1:0]     grant_idx;

  dmx_axi_wr_arb #(.NUM_REQ(NR), .IDX_W(IW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .gclk(gclk), .greset(greset),
    .s_avalid(s_avalid), .s_aready(s_aready), .s_aid(s_aid), .s_addr(s_addr),
    .s_awrite(s_awrite), .s_alen(s_alen), .s_aburst(s_aburst), .s_asize(s_asize),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wid(s_wid), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .m_avalid(m_avalid), .m_aready(m_aready), .m_aid(m_aid), .m_addr(m_addr),
    .m_awrite(m_awrite), .m_alen(m_alen), .m_aburst(m_aburst), .m_asize(m_asize),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wid(m_wid), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .grant_idx(grant_idx), .busy(busy), .err_len(err_len), .err_clr(err_clr)
  );

  typedef struct { logic [31:0] addr; logic [3:0] alen; int wlast_at; } burst_t;
  typedef struct { logic [63:0] data; logic [7:0] strb; logic last; } beat_t;
  typedef struct { logic [31:0] addr; logic [3:0] alen; } aexp_t;

  burst_t bq   [NR][$];
  beat_t  expw [NR][$];
  aexp_t  expa [NR][$];
  int     glog [$];

  int checks = 0, errors = 0;
  int beats_seen = 0;
  int aready_hold = 0;
  bit wtoggle = 1'b0;

  int     ph [NR];
  int     bt [NR];
  burst_t cur [NR];
  logic   hs_a [NR];
  logic   hs_w [NR];

  function automatic logic [63:0] pat(input int i, input logic [31:0] a, input int b);
    return {i[7:0], b[23:0], a};
  endfunction

  function automatic logic [7:0] spat(input int b);
    return 8'hFF ^ b[7:0];
  endfunction

  function automatic int nbeats(input burst_t b);
    return (b.wlast_at >= 0) ? b.wlast_at + 1 : int'(b.alen) + 1;
  endfunction

  // Queue a burst for requester i and record what the master side must see
  task automatic push_burst(input int i, input logic [31:0] a, input logic [3:0] alen,
                            input int wl);
    burst_t b;
    aexp_t  ea;
    beat_t  ew;
    b.addr = a; b.alen = alen; b.wlast_at = wl;
    ea.addr = a; ea.alen = alen;
    bq[i].push_back(b);
    expa[i].push_back(ea);
    for (int k = 0; k < nbeats(b); k++) begin
      ew.data = pat(i, a, k);
      ew.strb = spat(k);
      ew.last = (k == wl) || (k == int'(alen));
      expw[i].push_back(ew);
    end
  endtask

  // Requester engines and master-side ready generation
  always @(posedge gclk) begin
    #1;
    if (greset) begin
      for (int i = 0; i < NR; i++) ph[i] = 0;
      s_avalid = '0; s_wvalid = '0; s_wlast = '0;
      m_aready = 1'b0; m_wready = 1'b0;
    end else begin
      m_aready = (aready_hold > 0) ? 1'b0 : 1'b1;
      if (aready_hold > 0) aready_hold--;
      m_wready = wtoggle ? ~m_wready : 1'b1;
      for (int i = 0; i < NR; i++) begin
        if (ph[i] == 1 && hs_a[i]) begin
          ph[i] = 2; bt[i] = 0; s_avalid[i] = 1'b0;
        end else if (ph[i] == 2 && hs_w[i]) begin
          bt[i]++;
          if (bt[i] == nbeats(cur[i])) begin
            ph[i] = 0; s_wvalid[i] = 1'b0; s_wlast[i] = 1'b0;
          end
        end
        if (ph[i] == 2) begin
          s_wvalid[i]           = 1'b1;
          s_wdata[i*DW +: DW]   = pat(i, cur[i].addr, bt[i]);
          s_wstrb[i*SW +: SW]   = spat(bt[i]);
          s_wlast[i]            = (bt[i] == cur[i].wlast_at);
          s_wid[i*6 +: 6]       = 6'(10 + i);
        end
        if (ph[i] == 0 && bq[i].size() > 0) begin
          cur[i] = bq[i].pop_front();
          ph[i]  = 1;
          s_avalid[i]        = 1'b1;
          s_addr[i*AW +: AW] = cur[i].addr;
          s_alen[i*4 +: 4]   = cur[i].alen;
          s_aid[i*6 +: 6]    = 6'(20 + i);
          s_awrite[i]        = 1'b1;
          s_aburst[i*2 +: 2] = 2'd1;
          s_asize[i*2 +: 2]  = 2'd3;
        end
      end
    end
  end

  // Monitor: scoreboard pops on handshakes plus per-cycle protocol checks
  int          g, p_grant;
  logic        p_busy = 1'b0, p_end = 1'b0, p_await = 1'b0;
  logic [31:0] p_addr = '0;
  aexp_t       ma;
  beat_t       mw;
  always @(negedge gclk) begin
    if (greset) begin
      for (int i = 0; i < NR; i++) begin hs_a[i] = 1'b0; hs_w[i] = 1'b0; end
      p_busy = 1'b0; p_end = 1'b0; p_await = 1'b0;
    end else begin
      g = int'(grant_idx);
      for (int i = 0; i < NR; i++) begin
        hs_a[i] = s_avalid[i] & s_aready[i];
        hs_w[i] = s_wvalid[i] & s_wready[i];
        checks++;
        if ((s_wready[i] || s_aready[i]) && !(busy && g == i)) begin
          errors++;
          $display("FAIL ready_isolation req%0d: aready=%b wready=%b busy=%b grant=%0d, required 0",
                   i, s_aready[i], s_wready[i], busy, g);
        end
      end
      if (p_end) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL busy_after_last: busy=%b, required 0", busy);
        end
      end
      if (busy && p_busy) begin
        checks++;
        if (g != p_grant) begin
          errors++; $display("FAIL grant_stable: grant=%0d, required %0d", g, p_grant);
        end
      end
      if (p_await && m_avalid) begin
        checks++;
        if (m_addr !== p_addr) begin
          errors++; $display("FAIL addr_stable: m_addr=%h, required %h", m_addr, p_addr);
        end
      end
      if (m_avalid && m_aready) begin
        glog.push_back(g);
        checks++;
        if (expa[g].size() == 0) begin
          errors++; $display("FAIL addr_unexpected: grant=%0d addr=%h, required no request", g, m_addr);
        end else begin
          ma = expa[g].pop_front();
          if (m_addr !== ma.addr || m_alen !== ma.alen || m_aid !== 6'(20 + g) || m_awrite !== 1'b1) begin
            errors++;
            $display("FAIL addr_phase req%0d: addr=%h alen=%0d aid=%0d, required addr=%h alen=%0d aid=%0d",
                     g, m_addr, m_alen, m_aid, ma.addr, ma.alen, 20 + g);
          end
        end
      end
      p_end = 1'b0;
      if (m_wvalid && m_wready) begin
        beats_seen++;
        p_end = m_wlast;
        checks++;
        if (expw[g].size() == 0) begin
          errors++; $display("FAIL beat_unexpected: grant=%0d data=%h, required no beat", g, m_wdata);
        end else begin
          mw = expw[g].pop_front();
          if (m_wdata !== mw.data || m_wstrb !== mw.strb || m_wlast !== mw.last || m_wid !== 6'(10 + g)) begin
            errors++;
            $display("FAIL beat req%0d: data=%h strb=%h last=%b wid=%0d, required data=%h strb=%h last=%b wid=%0d",
                     g, m_wdata, m_wstrb, m_wlast, m_wid, mw.data, mw.strb, mw.last, 10 + g);
          end
        end
      end
      p_busy  = busy;
      p_grant = g;
      p_await = m_avalid && !m_aready;
      p_addr  = m_addr;
    end
  end

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge gclk); #1;
      done = !busy && s_avalid == '0 && ph[0] == 0 && ph[1] == 0 &&
             bq[0].size() == 0 && bq[1].size() == 0;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL idle_timeout: busy=%b, required 0 within %0d cycles", busy, budget); end
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (expw[i].size() != 0 || expa[i].size() != 0) begin
        errors++;
        $display("FAIL leftover req%0d: %0d beats %0d addrs pending, required 0", i, expw[i].size(), expa[i].size());
      end
    end
  endtask

  task automatic test_reset;
    greset = 1'b1;
    repeat (3) @(negedge gclk);
    checks++;
    if (busy !== 1'b0 || grant_idx !== '0 || err_len !== 1'b0 || m_avalid !== 1'b0 ||
        m_wvalid !== 1'b0 || s_aready !== '0 || s_wready !== '0 || m_addr !== '0 || m_wdata !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b grant=%0d err=%b mav=%b mwv=%b ar=%b wr=%b, required all 0",
               busy, grant_idx, err_len, m_avalid, m_wvalid, s_aready, s_wready);
    end
    checks++;
    if (dut.r_rr_ptr !== '0) begin errors++; $display("FAIL reset_rr: rr_ptr=%0d, required 0", dut.r_rr_ptr); end
    greset = 1'b0;
  endtask

  task automatic test_single;
    int b0 = beats_seen;
    push_burst(0, 32'h1000, 4'd3, 3);
    @(negedge gclk);
    checks++;
    if (s_avalid[0] !== 1'b1 || m_avalid !== 1'b0) begin
      errors++; $display("FAIL latency_pre: s_avalid=%b m_avalid=%b, required 1 and 0", s_avalid[0], m_avalid);
    end
    @(negedge gclk);
    checks++;
    if (m_avalid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL latency_1cyc: m_avalid=%b busy=%b, required 1 and 1", m_avalid, busy);
    end
    wait_idle(100);
    checks++;
    if (beats_seen - b0 != 4) begin errors++; $display("FAIL single_beats: got %0d, required 4", beats_seen - b0); end
    checks++;
    if (dut.r_rr_ptr !== 1'b1 || err_len !== 1'b0) begin
      errors++; $display("FAIL single_end: rr_ptr=%0d err=%b, required 1 and 0", dut.r_rr_ptr, err_len);
    end
  endtask

  task automatic test_contention;
    int g0;
    int exp_g [4];
    exp_g = '{0, 1, 0, 1};
    greset = 1'b1; @(negedge gclk); greset = 1'b0;
    g0 = glog.size();
    push_burst(0, 32'hA000, 4'd1, 1); push_burst(0, 32'hA100, 4'd1, 1);
    push_burst(1, 32'hB000, 4'd1, 1); push_burst(1, 32'hB100, 4'd1, 1);
    wait_idle(200);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (glog.size() <= g0 + k) begin
        errors++; $display("FAIL contention_grant%0d: missing, required %0d", k, exp_g[k]);
      end else if (glog[g0 + k] != exp_g[k]) begin
        errors++; $display("FAIL contention_grant%0d: got %0d, required %0d", k, glog[g0 + k], exp_g[k]);
      end
    end
  endtask

  task automatic test_backpressure;
    int b0 = beats_seen;
    aready_hold = 5; wtoggle = 1'b1;
    push_burst(0, 32'h2000, 4'd3, 3);
    push_burst(1, 32'h2800, 4'd1, 1);
    wait_idle(300);
    wtoggle = 1'b0;
    checks++;
    if (beats_seen - b0 != 6) begin errors++; $display("FAIL bp_beats: got %0d, required 6", beats_seen - b0); end
  endtask

  task automatic test_len_err;
    int b0 = beats_seen;
    push_burst(0, 32'h3000, 4'd3, 1);
    wait_idle(100);
    checks++;
    if (beats_seen - b0 != 2 || err_len !== 1'b1) begin
      errors++; $display("FAIL early_wlast: beats=%0d err=%b, required 2 and 1", beats_seen - b0, err_len);
    end
    err_clr = 1'b1; @(negedge gclk); err_clr = 1'b0; #1;
    checks++;
    if (err_len !== 1'b0) begin errors++; $display("FAIL err_clr_early: err=%b, required 0", err_len); end
    b0 = beats_seen;
    push_burst(1, 32'h4000, 4'd2, -1);
    wait_idle(100);
    checks++;
    if (beats_seen - b0 != 3 || err_len !== 1'b1) begin
      errors++; $display("FAIL missing_wlast: beats=%0d err=%b, required 3 and 1", beats_seen - b0, err_len);
    end
    err_clr = 1'b1; @(negedge gclk); err_clr = 1'b0; #1;
    checks++;
    if (err_len !== 1'b0) begin errors++; $display("FAIL err_clr_missing: err=%b, required 0", err_len); end
  endtask

  task automatic test_reset_mid;
    int b0 = beats_seen;
    int c = 0;
    push_burst(0, 32'h5000, 4'd7, 7);
    while (c < 100 && beats_seen - b0 < 2) begin @(negedge gclk); #1; c++; end
    checks++;
    if (beats_seen - b0 < 2) begin errors++; $display("FAIL mid_wait: beats=%0d, required 2", beats_seen - b0); end
    greset = 1'b1;
    @(negedge gclk);
    checks++;
    if (busy !== 1'b0 || m_wvalid !== 1'b0 || dut.r_rr_ptr !== '0) begin
      errors++; $display("FAIL mid_reset: busy=%b mwv=%b rr=%0d, required 0 0 0", busy, m_wvalid, dut.r_rr_ptr);
    end
    for (int i = 0; i < NR; i++) begin expw[i].delete(); expa[i].delete(); bq[i].delete(); end
    @(negedge gclk);
    greset = 1'b0;
    b0 = beats_seen;
    push_burst(1, 32'h6000, 4'd0, 0);
    wait_idle(100);
    checks++;
    if (glog.size() == 0 || glog[glog.size()-1] != 1 || beats_seen - b0 != 1 || err_len !== 1'b0) begin
      errors++; $display("FAIL post_reset_req1: beats=%0d err=%b, required grant 1, 1 beat, err 0", beats_seen - b0, err_len);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_backpressure;
    test_len_err;
    test_reset_mid;
    repeat (2) @(negedge gclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmx_axi_wr_arb.md
Name: dmx_axi_wr_arb

Overview:
Round-robin arbiter that shares one AXI-style write master port (address channel plus write-data channel) between NUM_REQ demux write engines.
- Grants one requester per burst and forwards its address phase, then its data beats until the burst completes.
- Only then rotates priority to the next requester.
- Checks beat count against alen and flags length mismatches.
- Sits between the demux instances and the system write interconnect.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
IDX_W, 1, grant index width, clog2(NUM_REQ)
ADDR_W, 32, address width
DATA_W, 64, write data width; strobe width is DATA_W/8

Ports:
gclk  in  1  clock; all logic on rising edge
greset  in  1  synchronous active-high reset
s_avalid  in  NUM_REQ  per-requester address valid
s_aready  out  NUM_REQ  per-requester address ready
s_aid  in  NUM_REQ*6  per-requester transaction ID
s_addr  in  NUM_REQ*ADDR_W  per-requester burst address
s_awrite  in  NUM_REQ  per-requester write qualifier
s_alen  in  NUM_REQ*4  per-requester burst length minus one
s_aburst  in  NUM_REQ*2  per-requester burst type
s_asize  in  NUM_REQ*2  per-requester beat size
s_wvalid  in  NUM_REQ  per-requester data valid
s_wready  out  NUM_REQ  per-requester data ready
s_wid  in  NUM_REQ*6  per-requester data ID
s_wdata  in  NUM_REQ*DATA_W  per-requester write data
s_wstrb  in  NUM_REQ*DATA_W/8  per-requester byte strobes
s_wlast  in  NUM_REQ  per-requester last beat
m_avalid, m_aready, m_aid[6], m_addr[ADDR_W], m_awrite, m_alen[4], m_aburst[2], m_asize[2]  out/in(m_aready)  master address channel
m_wvalid, m_wready, m_wid[6], m_wdata[DATA_W], m_wstrb[DATA_W/8], m_wlast  out/in(m_wready)  master data channel
grant_idx  out  IDX_W  index of current owner; valid when busy=1
busy  out  1  high from grant until burst end
err_len  out  1  sticky burst-length error
err_clr  in  1  clears err_len

Behaviour:
- Vectors are packed with requester i at bits [i*W +: W].
- Reset values: state IDLE, rr_ptr=0, grant_idx=0, busy=0, err_len=0, beat counter=0.
- Reset values of all valids/readies (m_avalid, m_wvalid, s_aready, s_wready): 0. Payload outputs: 0.
- Reset asserted mid-burst aborts the burst on the next edge; downstream must be reset together.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any s_avalid is set, select the first set bit scanning from rr_ptr upward with wrap.
  - Register grant_idx and set busy=1; go to ADDR.
  - No s_avalid set: stay in IDLE.
  - Latency from s_avalid to m_avalid is exactly 1 cycle.
- ADDR:
  - m_avalid and m_a* are combinational muxes of the granted requester.
  - s_aready[grant] = m_aready; all other s_aready are 0.
  - On m_avalid & m_aready: load beat counter with m_alen and go to DATA.
  - If the granted s_avalid drops before handshake (protocol violation), stay in ADDR.
- DATA:
  - m_wvalid and m_w* are muxed from the grant; s_wready[grant] = m_wready; all others 0.
  - m_wlast = s_wlast[grant] OR (counter==0).
  - On each beat handshake, decrement the counter.
  - Burst ends on the handshake where counter==0 or s_wlast[grant]=1, whichever comes first.
  - Either condition without the other sets err_len: wlast early, or wlast missing on the final beat.
  - On burst end: rr_ptr = (grant_idx+1) mod NUM_REQ, busy=0, go to IDLE.
  - This leaves one mandatory idle cycle between bursts.
- s_wvalid outside DATA, or from a non-granted requester, is ignored (ready held 0).
- s_wid is passed through, not checked against s_aid.
- err_len: err_clr clears it; a set and a clear in the same cycle resolve to set.
- Maximum burst is 16 beats (alen=15). alen=0 is a single beat, and that beat carries m_wlast=1.
- Fairness: a requester that keeps s_avalid high waits at most NUM_REQ-1 bursts.

Test Plan:
- Single request, NUM_REQ=2: req0 alen=3, addr 0x1000, m_aready=1, m_wready=1.
  - m_avalid 1 cycle after s_avalid; 4 beats forwarded; m_wlast on beat 4.
  - busy falls after beat 4; rr_ptr=1; err_len=0.
- Contention: both requesters assert avalid continuously with alen=1.
  - Grants go 0,1,0,1.
  - grant_idx never changes mid-burst; one idle cycle between bursts.
- Backpressure: m_aready low 5 cycles, then m_wready toggling 1,0,1,0.
  - m_a* payload stable while m_avalid is high.
  - Exactly alen+1 beats are counted; non-granted s_wready stays 0 throughout.
- Length error: alen=3 with s_wlast on beat 2 → burst ends after beat 2, err_len=1. Pulse err_clr → err_len=0.
- Length error, missing wlast: alen=2 with no s_wlast → m_wlast forced on beat 3, err_len=1.
- Reset mid-burst: greset asserted during beat 2 of an alen=7 burst.
  - Next cycle: busy=0, m_wvalid=0, rr_ptr=0.
  - A new req1 request is then granted normally.
